pano_i2s_dac: RTL and testbench

Audio output stage between the Centipede audio generator and the board's audio codec. It takes the 8-bit unsigned sound sample produced by the game audio block and converts it to a 16-bit signed stereo (mono-duplicated) I2S stream. It also generates the codec master clock, bit clock and LR clocks, and drives the `audio_mclk` / `audio_bclk` / `audio_dacdat` / `audio_daclrc` / `audio_adclrc` pins.

---
 rtl/pano_audio_pkg.sv | 23 ++
 rtl/pano_audio_clkgen.sv | 75 +++++++
 rtl/pano_i2s_dac.sv | 84 ++++++++
 tb/tb_pano_i2s_dac.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pano_audio_pkg.sv
// Shared constants and sample conversion for the Pano audio output path.
// Used by the I2S clock generator and the DAC serialiser.
package pano_audio_pkg;

   localparam int FRAME_SLOTS   = 32;
   localparam int CH_BITS       = 16;
   localparam int SLOT_W        = $clog2(FRAME_SLOTS);
   localparam int MCLK_HALF_DEF = 1;
   localparam int BCLK_HALF_DEF = 8;

   typedef logic [CH_BITS-1:0] pcm16_t;

   // Unsigned 8-bit (0x80 = silence) to signed 16-bit; mute forces digital zero.
   function automatic pcm16_t u8_to_s16(input logic [7:0] sample, input logic mute);
      pcm16_t s16;
      s16 = {~sample[7], sample[6:0], 8'h00};
      if (mute) begin
         s16 = '0;
      end
      return s16;
   endfunction

endpackage

// File: rtl/pano_audio_clkgen.sv
// Codec clock generator: free-running MCLK plus BCLK / slot counters.
// bclk_fall and frame_start flag the clock edge that enters a new slot / slot 0.
module pano_audio_clkgen
   import pano_audio_pkg::*;
#(
   parameter int MCLK_HALF = MCLK_HALF_DEF,
   parameter int BCLK_HALF = BCLK_HALF_DEF
) (
   input  logic              clk_audio,
   input  logic              reset_audio,
   output logic              audio_mclk,
   output logic              audio_bclk,
   output logic              bclk_fall,
   output logic              frame_start,
   output logic [SLOT_W-1:0] slot
);

   localparam int BCNT_W = $clog2(2 * BCLK_HALF);
   localparam int MCNT_W = $clog2(MCLK_HALF + 1);
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(2 * BCLK_HALF - 1);
   localparam logic [BCNT_W-1:0] BCNT_HIGH = BCNT_W'(BCLK_HALF);
   localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MCLK_HALF - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_SLOTS - 1);

   logic              run_reg;
   logic [BCNT_W-1:0] bcnt_reg, bcnt_next;
   logic [SLOT_W-1:0] slot_reg, slot_next;
   logic [MCNT_W-1:0] mcnt_reg;
   logic              mclk_reg;
   logic              bclk_reg;
   logic              bcnt_wrap;

   // The first edge after reset release only starts the frame; counting begins after it,
   // so the first active cycle sits at slot 0 / bcnt 0 with the capture strobe high.
   always_comb begin
      bcnt_wrap   = (bcnt_reg == BCNT_LAST);
      bcnt_next   = bcnt_reg;
      slot_next   = slot_reg;
      if (run_reg) begin
         bcnt_next = bcnt_wrap ? '0 : bcnt_reg + BCNT_W'(1);
         if (bcnt_wrap) begin
            slot_next = (slot_reg == SLOT_LAST) ? '0 : slot_reg + SLOT_W'(1);
         end
      end
      bclk_fall   = !run_reg || bcnt_wrap;
      frame_start = !run_reg || (bcnt_wrap && (slot_reg == SLOT_LAST));
   end

   always_ff @(posedge clk_audio) begin
      if (reset_audio) begin
         run_reg  <= 1'b0;
         bcnt_reg <= '0;
         slot_reg <= '0;
         mcnt_reg <= '0;
         mclk_reg <= 1'b0;
         bclk_reg <= 1'b0;
      end else begin
         run_reg  <= 1'b1;
         bcnt_reg <= bcnt_next;
         slot_reg <= slot_next;
         bclk_reg <= (bcnt_next >= BCNT_HIGH);
         if (mcnt_reg == MCNT_LAST) begin
            mcnt_reg <= '0;
            mclk_reg <= ~mclk_reg;
         end else begin
            mcnt_reg <= mcnt_reg + MCNT_W'(1);
         end
      end
   end

   assign audio_mclk = mclk_reg;
   assign audio_bclk = bclk_reg;
   assign slot       = slot_reg;

endmodule

// File: rtl/pano_i2s_dac.sv
// 8-bit game audio to 16-bit mono-duplicated I2S stream for the board codec.
// Captures one sample per frame and serialises it MSB first with the I2S one-slot delay.
module pano_i2s_dac
   import pano_audio_pkg::*;
#(
   parameter int MCLK_HALF = MCLK_HALF_DEF,
   parameter int BCLK_HALF = BCLK_HALF_DEF
) (
   input  logic       clk_audio,
   input  logic       reset_audio,
   input  logic [7:0] sample_i,
   input  logic       mute_i,
   output logic       sample_strobe_o,
   output logic       audio_mclk,
   output logic       audio_bclk,
   output logic       audio_daclrc,
   output logic       audio_adclrc,
   output logic       audio_dacdat
);

   localparam int WORD_BITS = 2 * CH_BITS;
   localparam logic [SLOT_W-1:0] LAST_LEFT_SLOT = SLOT_W'(FRAME_SLOTS / 2 - 1);

   logic                 bclk_fall;
   logic                 frame_start;
   logic [SLOT_W-1:0]    slot;
   pcm16_t               s16;
   logic [WORD_BITS-1:0] frame_word;
   logic [WORD_BITS-1:0] shift_reg;
   logic                 dacdat_reg;
   logic                 lrc_reg;
   logic                 strobe_reg;

   pano_audio_clkgen #(
      .MCLK_HALF (MCLK_HALF),
      .BCLK_HALF (BCLK_HALF)
   ) u_clkgen (
      .clk_audio   (clk_audio),
      .reset_audio (reset_audio),
      .audio_mclk  (audio_mclk),
      .audio_bclk  (audio_bclk),
      .bclk_fall   (bclk_fall),
      .frame_start (frame_start),
      .slot        (slot)
   );

   assign s16 = u8_to_s16(sample_i, mute_i);

   // Mono source: both channels of the frame word carry the same sample.
   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      assign frame_word[gi*CH_BITS +: CH_BITS] = s16;
   end

   // dacdat_reg is the one-slot delay: it takes the shifter MSB before each shift,
   // so slot 0 still carries the previous frame's right-channel LSB.
   always_ff @(posedge clk_audio) begin
      if (reset_audio) begin
         shift_reg  <= '0;
         dacdat_reg <= 1'b0;
         lrc_reg    <= 1'b0;
         strobe_reg <= 1'b0;
      end else begin
         strobe_reg <= frame_start;
         if (bclk_fall) begin
            dacdat_reg <= shift_reg[WORD_BITS-1];
            if (frame_start) begin
               shift_reg <= frame_word;
               lrc_reg   <= 1'b0;
            end else begin
               shift_reg <= {shift_reg[WORD_BITS-2:0], 1'b0};
               if (slot == LAST_LEFT_SLOT) begin
                  lrc_reg <= 1'b1;
               end
            end
         end
      end
   end

   assign sample_strobe_o = strobe_reg;
   assign audio_daclrc    = lrc_reg;
   assign audio_adclrc    = lrc_reg;
   assign audio_dacdat    = dacdat_reg;

endmodule

// File: tb/tb_pano_i2s_dac.sv
// Self-checking bench for pano_i2s_dac at default rates (BCLK 16 cycles, frame 512 cycles).
// Expected stream comes from a frame-level model: time index -> slot -> bit of the captured word.
module tb_pano_i2s_dac;

   logic       clk = 1'b0;
   logic       reset_audio = 1'b1;
   logic [7:0] sample_i = 8'h80;
   logic       mute_i = 1'b0;
   logic       sample_strobe_o;
   logic       audio_mclk;
   logic       audio_bclk;
   logic       audio_daclrc;
   logic       audio_adclrc;
   logic       audio_dacdat;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model state: t = cycles since the first active cycle (-1 while in reset).
   int          t = -1;
   logic [31:0] cur_word = '0;
   logic        last_bit = 1'b0;

   always #5 clk = ~clk;

   pano_i2s_dac dut (
      .clk_audio       (clk),
      .reset_audio     (reset_audio),
      .sample_i        (sample_i),
      .mute_i          (mute_i),
      .sample_strobe_o (sample_strobe_o),
      .audio_mclk      (audio_mclk),
      .audio_bclk      (audio_bclk),
      .audio_daclrc    (audio_daclrc),
      .audio_adclrc    (audio_adclrc),
      .audio_dacdat    (audio_dacdat)
   );

   function automatic logic [15:0] ref_s16(input logic [7:0] s, input logic m);
      int v;
      v = (int'(s) - 128) * 256;
      return m ? 16'h0000 : v[15:0];
   endfunction

   function automatic logic exp_dat(input int tt);
      int sl;
      sl = (tt / 16) % 32;
      if (sl == 0) return last_bit;
      return cur_word[32 - sl];
   endfunction

   function automatic logic exp_lrc(input int tt);
      return ((tt / 16) % 32) >= 16;
   endfunction

   function automatic logic exp_bclk(input int tt);
      return (tt % 16) >= 8;
   endfunction

   function automatic logic exp_mclk(input int tt);
      return ((tt + 1) % 2) == 1;
   endfunction

   // Advance one clock; the model captures the inputs present at a frame-start edge.
   task automatic tick();
      logic [15:0] s;
      if (reset_audio) begin
         t        = -1;
         cur_word = '0;
         last_bit = 1'b0;
      end else begin
         t = t + 1;
         if (t % 512 == 0) begin
            s        = ref_s16(sample_i, mute_i);
            last_bit = cur_word[0];
            cur_word = {s, s};
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic align_frame();
      tick();
      while (t % 512 != 0) tick();
   endtask

   // Collect the bit present at each BCLK rising edge for one frame (starting at a capture).
   task automatic decode_frame(input int chg_at, input logic [7:0] chg_s, input logic chg_m,
                               output logic [15:0] l, output logic [15:0] r);
      logic b [32];
      for (int i = 0; i < 32; i++) b[i] = 1'b0;
      for (int i = 0; i < 520; i++) begin
         if (i == chg_at) begin
            sample_i = chg_s;
            mute_i   = chg_m;
         end
         tick();
         if (t % 16 == 8) b[(t / 16) % 32] = audio_dacdat;
      end
      for (int k = 0; k < 16; k++) l[15-k] = b[1+k];
      for (int k = 0; k < 15; k++) r[15-k] = b[17+k];
      r[0] = b[0];
   endtask

   task automatic test_reset();
      reset_audio = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if ({audio_mclk, audio_bclk, audio_daclrc, audio_adclrc, audio_dacdat, sample_strobe_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs cycle=%0d actual=%b required=000000", i,
                     {audio_mclk, audio_bclk, audio_daclrc, audio_adclrc, audio_dacdat, sample_strobe_o});
         end
      end
      reset_audio = 1'b0;
      tick();
      n_cmp++;
      if ({sample_strobe_o, audio_bclk, audio_daclrc, audio_dacdat} !== 4'b1000) begin
         n_fail++;
         $display("FAIL first_active actual(strobe,bclk,lrc,dat)=%b required=1000",
                  {sample_strobe_o, audio_bclk, audio_daclrc, audio_dacdat});
      end
      for (int i = 1; i <= 512; i++) begin
         tick();
         n_cmp++;
         if (sample_strobe_o !== (i == 512)) begin
            n_fail++;
            $display("FAIL strobe_spacing cycle=%0d actual=%b required=%b", i, sample_strobe_o, (i == 512));
         end
      end
      $display("test_reset done t=%0d", t);
   endtask

   task automatic test_clock_rates();
      int hi_run = 0;
      int lo_run = 0;
      logic prev_bclk;
      prev_bclk = audio_bclk;
      for (int i = 0; i < 1024; i++) begin
         tick();
         n_cmp++;
         if ({audio_bclk, audio_mclk, audio_daclrc, sample_strobe_o, audio_dacdat} !==
             {exp_bclk(t), exp_mclk(t), exp_lrc(t), (t % 512 == 0), exp_dat(t)}) begin
            n_fail++;
            $display("FAIL clk_rates t=%0d actual(bclk,mclk,lrc,strb,dat)=%b required=%b", t,
                     {audio_bclk, audio_mclk, audio_daclrc, sample_strobe_o, audio_dacdat},
                     {exp_bclk(t), exp_mclk(t), exp_lrc(t), (t % 512 == 0), exp_dat(t)});
         end
         n_cmp++;
         if (audio_adclrc !== audio_daclrc) begin
            n_fail++;
            $display("FAIL adclrc t=%0d actual=%b required=%b", t, audio_adclrc, audio_daclrc);
         end
         if (audio_bclk !== prev_bclk) begin
            n_cmp++;
            if (audio_bclk && lo_run != 8 && i > 16) begin
               n_fail++;
               $display("FAIL bclk_low_len t=%0d actual=%0d required=8", t, lo_run);
            end else if (!audio_bclk && hi_run != 8 && i > 16) begin
               n_fail++;
               $display("FAIL bclk_high_len t=%0d actual=%0d required=8", t, hi_run);
            end
            hi_run = 0;
            lo_run = 0;
         end
         if (audio_bclk) hi_run++; else lo_run++;
         prev_bclk = audio_bclk;
      end
      $display("test_clock_rates done t=%0d", t);
   endtask

   task automatic test_full_scale();
      logic [15:0] l, r;
      sample_i = 8'hFF;
      mute_i   = 1'b0;
      align_frame();
      decode_frame(-1, 8'hFF, 1'b0, l, r);
      n_cmp++;
      if (l !== 16'h7F00) begin
         n_fail++;
         $display("FAIL fullscale_left actual=%h required=7f00", l);
      end
      n_cmp++;
      if (r !== 16'h7F00) begin
         n_fail++;
         $display("FAIL fullscale_right actual=%h required=7f00", r);
      end
      $display("test_full_scale L=%h R=%h", l, r);
   endtask

   task automatic test_neg_silence();
      logic [15:0] l, r;
      logic [7:0]  smp [2];
      logic [15:0] req [2];
      smp[0] = 8'h00; req[0] = 16'h8000;
      smp[1] = 8'h80; req[1] = 16'h0000;
      for (int k = 0; k < 2; k++) begin
         sample_i = smp[k];
         mute_i   = 1'b0;
         align_frame();
         decode_frame(-1, smp[k], 1'b0, l, r);
         n_cmp++;
         if (l !== req[k] || r !== req[k]) begin
            n_fail++;
            $display("FAIL neg_silence sample=%h actual=%h/%h required=%h", smp[k], l, r, req[k]);
         end
         $display("test_neg_silence sample=%h L=%h R=%h", smp[k], l, r);
      end
   endtask

   task automatic test_mute_late();
      logic [15:0] l, r;
      sample_i = 8'hFF;
      mute_i   = 1'b1;
      align_frame();
      decode_frame(5 * 16, 8'h00, 1'b0, l, r);
      n_cmp++;
      if (l !== 16'h0000 || r !== 16'h0000) begin
         n_fail++;
         $display("FAIL mute_frame actual=%h/%h required=0000", l, r);
      end
      $display("test_mute_late muted L=%h R=%h", l, r);
      align_frame();
      decode_frame(-1, 8'h00, 1'b0, l, r);
      n_cmp++;
      if (l !== 16'h8000 || r !== 16'h8000) begin
         n_fail++;
         $display("FAIL late_change_next actual=%h/%h required=8000", l, r);
      end
      $display("test_mute_late next L=%h R=%h", l, r);
   endtask

   task automatic test_reset_mid();
      sample_i = 8'h00;
      mute_i   = 1'b0;
      align_frame();
      while (t % 512 != 20 * 16 + 3) tick();
      reset_audio = 1'b1;
      tick();
      n_cmp++;
      if ({audio_mclk, audio_bclk, audio_daclrc, audio_adclrc, audio_dacdat, sample_strobe_o} !== 6'b0) begin
         n_fail++;
         $display("FAIL midreset_outputs actual=%b required=000000",
                  {audio_mclk, audio_bclk, audio_daclrc, audio_adclrc, audio_dacdat, sample_strobe_o});
      end
      reset_audio = 1'b0;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (i == 0) begin
            n_cmp++;
            if ({sample_strobe_o, audio_bclk, audio_daclrc} !== 3'b100) begin
               n_fail++;
               $display("FAIL midreset_restart actual(strb,bclk,lrc)=%b required=100",
                        {sample_strobe_o, audio_bclk, audio_daclrc});
            end
         end
         if (i < 16) begin
            n_cmp++;
            if (audio_dacdat !== 1'b0) begin
               n_fail++;
               $display("FAIL midreset_slot0_dat t=%0d actual=%b required=0", t, audio_dacdat);
            end
         end
         n_cmp++;
         if ({audio_dacdat, audio_daclrc, sample_strobe_o} !== {exp_dat(t), exp_lrc(t), (t % 512 == 0)}) begin
            n_fail++;
            $display("FAIL midreset_stream t=%0d actual=%b required=%b", t,
                     {audio_dacdat, audio_daclrc, sample_strobe_o}, {exp_dat(t), exp_lrc(t), (t % 512 == 0)});
         end
      end
      $display("test_reset_mid done t=%0d", t);
   endtask

   task automatic test_random();
      for (int i = 0; i < 2560; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            sample_i = 8'($urandom);
            mute_i   = ($urandom_range(0, 4) == 0);
         end
         tick();
         n_cmp++;
         if ({audio_dacdat, audio_daclrc, audio_bclk, sample_strobe_o} !==
             {exp_dat(t), exp_lrc(t), exp_bclk(t), (t % 512 == 0)}) begin
            n_fail++;
            $display("FAIL random_stream t=%0d word=%h actual=%b required=%b", t, cur_word,
                     {audio_dacdat, audio_daclrc, audio_bclk, sample_strobe_o},
                     {exp_dat(t), exp_lrc(t), exp_bclk(t), (t % 512 == 0)});
         end
         if (t % 512 == 0) $display("test_random capture t=%0d word=%h", t, cur_word);
      end
   endtask

   initial begin
      test_reset();
      test_clock_rates();
      test_full_scale();
      test_neg_silence();
      test_mute_late();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
